// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide memory sequencer: access lengths, FSM states,
// bus widths and the I/O window base.
package mem_ctrl_pkg;

  localparam int ADDR_RANGE = 32;
  localparam int DATA_RANGE = 32;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // The reserved 11 encoding behaves as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_bytes = 3'd1;
      LEN_H:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_rdata_fmt.sv
// Read-data formatter: keeps the low 1/2/4 assembled byte lanes and zero- or
// sign-extends from the top kept bit. Purely combinational.
module mem_ctrl_rdata_fmt
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw_dat,
  input  logic [1:0]  len,
  input  logic        sext,
  output logic [31:0] fmt_dat
);

  always_comb begin
    case (len)
      LEN_B:   fmt_dat = {{24{sext & raw_dat[7]}}, raw_dat[7:0]};
      LEN_H:   fmt_dat = {{16{sext & raw_dat[15]}}, raw_dat[15:0]};
      default: fmt_dat = raw_dat;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF/LS onto the byte-wide memory bus; read done N+2 cycles, write done
// N+1 cycles after accept. rdy_in low freezes state (reads restart, writes re-drive).
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_RANGE,
  parameter int DATA_W = DATA_RANGE
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic              if_done_out,
  output logic [DATA_W-1:0] if_inst_out,
  input  logic              ls_req_in,
  input  logic              ls_wr_in,
  input  logic [ADDR_W-1:0] ls_addr_in,
  input  logic [1:0]        ls_len_in,
  input  logic              ls_sext_in,
  input  logic [DATA_W-1:0] ls_wdata_in,
  output logic              ls_done_out,
  output logic [DATA_W-1:0] ls_rdata_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out
);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        len_q, len_d;
  logic              sext_q, sext_d;
  logic              wr_q, wr_d;
  logic              is_if_q, is_if_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [2:0]        nbytes;
  logic [DATA_W-1:0] wsh;
  logic [31:0]       fmt_dat;

  assign nbytes = len_bytes(len_q);

  mem_ctrl_rdata_fmt u_fmt (
    .raw_dat (rbuf_q),
    .len     (len_q),
    .sext    (sext_q),
    .fmt_dat (fmt_dat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    sext_d  = sext_q;
    wr_d    = wr_q;
    is_if_d = is_if_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    inst_d  = inst_q;
    rdata_d = rdata_q;
    ram_a_out    = '0;
    ram_dout_out = '0;
    ram_wr_out   = 1'b0;
    if_done_out  = 1'b0;
    ls_done_out  = 1'b0;
    wsh = wdata_q >> {cnt_q[1:0], 3'b000};

    case (state_q)
      ST_IDLE: begin
        if (rdy_in) begin
          if (ls_req_in) begin
            state_d = ls_wr_in ? ST_WRITE : ST_READ;
            is_if_d = 1'b0;
            wr_d    = ls_wr_in;
            addr_d  = ls_addr_in;
            len_d   = ls_len_in;
            sext_d  = ls_sext_in;
            wdata_d = ls_wdata_in;
            cnt_d   = '0;
          end else if (if_req_in && !if_flush_in) begin
            state_d = ST_READ;
            is_if_d = 1'b1;
            wr_d    = 1'b0;
            addr_d  = if_addr_in;
            len_d   = LEN_W;
            sext_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      // cnt_q counts addresses issued; each cycle captures the byte addressed one cycle earlier.
      ST_READ: begin
        if (cnt_q < nbytes) ram_a_out = addr_q + ADDR_W'(cnt_q);
        if (is_if_q && if_flush_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!rdy_in) begin
          cnt_d = '0;
        end else begin
          case (cnt_q)
            3'd1:    rbuf_d[7:0]   = ram_din_in;
            3'd2:    rbuf_d[15:8]  = ram_din_in;
            3'd3:    rbuf_d[23:16] = ram_din_in;
            3'd4:    rbuf_d[31:24] = ram_din_in;
            default: ;
          endcase
          if (cnt_q == nbytes) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_WRITE: begin
        ram_a_out    = addr_q + ADDR_W'(cnt_q);
        ram_dout_out = wsh[7:0];
        ram_wr_out   = rdy_in;
        if (rdy_in) begin
          if (cnt_q == nbytes - 3'd1) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        if (is_if_q && if_flush_in) begin
          state_d = ST_IDLE;
        end else if (rdy_in) begin
          state_d = ST_IDLE;
          if (is_if_q) begin
            if_done_out = 1'b1;
            inst_d      = fmt_dat;
          end else begin
            ls_done_out = 1'b1;
            if (!wr_q) rdata_d = fmt_dat;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Results are visible in the done cycle itself, then held in the _q registers.
  assign if_inst_out  = if_done_out ? fmt_dat : inst_q;
  assign ls_rdata_out = (ls_done_out && !wr_q) ? fmt_dat : rdata_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= LEN_B;
      sext_q  <= 1'b0;
      wr_q    <= 1'b0;
      is_if_q <= 1'b0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      inst_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sext_q  <= sext_d;
      wr_q    <= wr_d;
      is_if_q <= is_if_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide memory model plus scoreboards of expected
// completions (with cycle) and expected bus writes.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_flush_in;
  logic        if_done_out;
  logic [31:0] if_inst_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [31:0] ls_addr_in;
  logic [1:0]  ls_len_in;
  logic        ls_sext_in;
  logic [31:0] ls_wdata_in;
  logic        ls_done_out;
  logic [31:0] ls_rdata_out;
  logic [7:0]  ram_din_in;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_a_out;
  logic        ram_wr_out;

  mem_ctrl dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_flush_in  (if_flush_in),
    .if_done_out  (if_done_out),
    .if_inst_out  (if_inst_out),
    .ls_req_in    (ls_req_in),
    .ls_wr_in     (ls_wr_in),
    .ls_addr_in   (ls_addr_in),
    .ls_len_in    (ls_len_in),
    .ls_sext_in   (ls_sext_in),
    .ls_wdata_in  (ls_wdata_in),
    .ls_done_out  (ls_done_out),
    .ls_rdata_out (ls_rdata_out),
    .ram_din_in   (ram_din_in),
    .ram_dout_out (ram_dout_out),
    .ram_a_out    (ram_a_out),
    .ram_wr_out   (ram_wr_out)
  );

  always #5 clk_in = ~clk_in;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int k;
  logic [31:0] last_ld = 32'h0;

  typedef struct {
    bit          is_if;
    logic [31:0] dat;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  done_t dq[$];
  wr_t   wq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Initial memory image; bytes written by the DUT override it.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: init_byte = 8'h13;
      32'h101: init_byte = 8'h05;
      32'h104: init_byte = 8'h93;
      32'h106: init_byte = 8'h10;
      32'h200: init_byte = 8'h80;
      32'h201: init_byte = 8'h7F;
      32'h300: init_byte = 8'hFE;
      32'h301: init_byte = 8'hFF;
      32'h400: init_byte = 8'hEF;
      32'h401: init_byte = 8'hBE;
      32'h402: init_byte = 8'hAD;
      32'h403: init_byte = 8'hDE;
      32'hFFFF_FFFF: init_byte = 8'h34;
      32'h0: init_byte = 8'h92;
      default: init_byte = 8'h00;
    endcase
  endfunction

  logic [7:0] mem [logic [31:0]];

  always @(posedge clk_in) begin
    ram_din_in <= mem.exists(ram_a_out) ? mem[ram_a_out] : init_byte(ram_a_out);
    if (ram_wr_out) mem[ram_a_out] = ram_dout_out;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    done_t e;
    wr_t   w;
    if (if_done_out || ls_done_out) begin
      if (dq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        chk("done_port", {31'b0, if_done_out}, {31'b0, e.is_if});
        chk("done_dat", e.is_if ? if_inst_out : ls_rdata_out, e.dat);
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    if (ram_wr_out) begin
      if (wq.size() == 0) begin
        chk("spurious_wr", ram_a_out, 32'hFFFF_FFFF);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", ram_a_out, w.a);
        chk("wr_dat", {24'b0, ram_dout_out}, {24'b0, w.d});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic ls_issue(input bit wr, input logic [31:0] a, input logic [1:0] len,
                          input bit sext, input logic [31:0] wd);
    ls_req_in   = 1'b1;
    ls_wr_in    = wr;
    ls_addr_in  = a;
    ls_len_in   = len;
    ls_sext_in  = sext;
    ls_wdata_in = wd;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] sh;
      sh = d >> (8 * i);
      wq.push_back('{a: a + 32'(i), d: sh[7:0]});
    end
  endtask

  task automatic push_done(input bit is_if, input logic [31:0] d, input int c);
    dq.push_back('{is_if: is_if, dat: d, cyc: c});
    if (!is_if) last_ld = d;
  endtask

  // Waits for the chosen port's done pulse, then drops that request at the following edge.
  task automatic wait_done(input bit is_if, input string tag);
    int n;
    n = 0;
    @(negedge clk_in);
    while (!(is_if ? if_done_out : ls_done_out) && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 32'd1, 32'd0);
    @(posedge clk_in);
    #1;
    if (is_if) if_req_in = 1'b0;
    else ls_req_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    if_req_in = 1'b0;
    if_addr_in = '0;
    if_flush_in = 1'b0;
    ls_req_in = 1'b0;
    ls_wr_in = 1'b0;
    ls_addr_in = '0;
    ls_len_in = 2'b00;
    ls_sext_in = 1'b0;
    ls_wdata_in = '0;
    tick(3);
    chk("rst_if_done", {31'b0, if_done_out}, 32'd0);
    chk("rst_ls_done", {31'b0, ls_done_out}, 32'd0);
    chk("rst_if_inst", if_inst_out, 32'd0);
    chk("rst_ls_rdata", ls_rdata_out, 32'd0);
    chk("rst_ram_a", ram_a_out, 32'd0);
    chk("rst_ram_dout", {24'b0, ram_dout_out}, 32'd0);
    chk("rst_ram_wr", {31'b0, ram_wr_out}, 32'd0);
    rst_n_in = 1'b1;
    tick(2);

    // Word fetch, with per-cycle address check.
    k = cyc;
    if_req_in = 1'b1;
    if_addr_in = 32'h100;
    push_done(1'b1, 32'h0000_0513, k + 6);
    @(negedge clk_in);
    chk("t1_idle_a", ram_a_out, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_in);
      chk("t1_addr", ram_a_out, 32'h100 + 32'(i - 1));
    end
    wait_done(1'b1, "t1");

    // Simultaneous requests: LS wins, IF accepted right after LS done.
    k = cyc;
    if_req_in = 1'b1;
    if_addr_in = 32'h104;
    ls_issue(1'b0, 32'h200, 2'b00, 1'b1, 32'h0);
    push_done(1'b0, 32'hFFFF_FF80, k + 3);
    push_done(1'b1, 32'h0010_0093, k + 10);
    wait_done(1'b0, "t2_ls");
    wait_done(1'b1, "t2_if");

    // Word store.
    k = cyc;
    ls_issue(1'b1, 32'h1000, 2'b10, 1'b0, 32'h1122_3344);
    push_wr(32'h1000, 32'h1122_3344, 4);
    push_done(1'b0, last_ld, k + 5);
    wait_done(1'b0, "t3");

    // Halfword load wrapping across the top of the address space.
    k = cyc;
    ls_issue(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0);
    push_done(1'b0, 32'hFFFF_9234, k + 4);
    wait_done(1'b0, "t_wrap");

    // Positive sign-extended byte with DONE frozen for two cycles.
    k = cyc;
    ls_issue(1'b0, 32'h201, 2'b00, 1'b1, 32'h0);
    push_done(1'b0, 32'h0000_007F, k + 5);
    tick(3);
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("t_dfrz_done", {31'b0, ls_done_out}, 32'd0);
    tick(2);
    rdy_in = 1'b1;
    wait_done(1'b0, "t_dfrz");

    // Flush in cycle 2 of a fetch; pending LS goes next.
    k = cyc;
    if_req_in = 1'b1;
    if_addr_in = 32'h100;
    tick(1);
    ls_issue(1'b0, 32'h300, 2'b01, 1'b0, 32'h0);
    tick(1);
    if_flush_in = 1'b1;
    if_req_in = 1'b0;
    tick(1);
    if_flush_in = 1'b0;
    push_done(1'b0, 32'h0000_FFFE, k + 7);
    @(negedge clk_in);
    chk("t4_idle_a", ram_a_out, 32'd0);
    wait_done(1'b0, "t4");

    // rdy low for 3 cycles during byte 2 of a word fetch: restart from byte 0.
    k = cyc;
    if_req_in = 1'b1;
    if_addr_in = 32'h400;
    push_done(1'b1, 32'hDEAD_BEEF, k + 10);
    tick(2);
    rdy_in = 1'b0;
    tick(3);
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("t5_restart_a", ram_a_out, 32'h400);
    wait_done(1'b1, "t5a");

    // rdy low during a halfword store: no write strobe while paused.
    k = cyc;
    ls_issue(1'b1, 32'h500, 2'b01, 1'b0, 32'h1234_A5B6);
    push_wr(32'h500, 32'h1234_A5B6, 2);
    push_done(1'b0, last_ld, k + 6);
    tick(2);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("t5_wr_paused", {31'b0, ram_wr_out}, 32'd0);
    end
    @(posedge clk_in);
    #1;
    rdy_in = 1'b1;
    wait_done(1'b0, "t5b");

    // Reset in the middle of a word store.
    k = cyc;
    ls_issue(1'b1, 32'h600, 2'b10, 1'b0, 32'hCAFE_BABE);
    push_wr(32'h600, 32'hCAFE_BABE, 1);
    tick(2);
    rst_n_in = 1'b0;
    ls_req_in = 1'b0;
    #1;
    chk("t6_wr", {31'b0, ram_wr_out}, 32'd0);
    chk("t6_a", ram_a_out, 32'd0);
    chk("t6_dout", {24'b0, ram_dout_out}, 32'd0);
    chk("t6_rdata", ls_rdata_out, 32'd0);
    tick(2);
    rst_n_in = 1'b1;
    tick(1);
    k = cyc;
    ls_issue(1'b0, 32'h600, 2'b00, 1'b0, 32'h0);
    push_done(1'b0, 32'h0000_00BE, k + 3);
    wait_done(1'b0, "t6");

    tick(3);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port arbiter and sequencer for the byte-wide external memory bus.
- Shared by two requesters: instruction fetch (IF) and the load/store stage (MEM).
- Converts 1/2/4-byte little-endian accesses into per-byte bus cycles and assembles the read data; owns `mem_a`, `mem_dout` and `mem_wr` at the cpu top.
- Memory reads return data one cycle after the address is driven; writes complete in the cycle they are driven.

Parameters:
- ADDR_W, 32, address width of requests and bus.
- DATA_W, 32, request data width.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low pauses the block
- if_req_in  in  1  IF fetch request (level, held until done)
- if_addr_in  in  32  fetch address
- if_flush_in  in  1  abort pending/in-flight fetch
- if_done_out  out  1  one-cycle pulse: fetch complete
- if_inst_out  out  32  fetched instruction
- ls_req_in  in  1  load/store request (level, held until done)
- ls_wr_in  in  1  1 = store
- ls_addr_in  in  32  access address
- ls_len_in  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ls_sext_in  in  1  sign-extend load result
- ls_wdata_in  in  32  store data (low bytes used)
- ls_done_out  out  1  one-cycle pulse: access complete
- ls_rdata_out  out  32  load result
- ram_din_in  in  8  memory data in
- ram_dout_out  out  8  memory data out
- ram_a_out  out  32  memory address
- ram_wr_out  out  1  1 = write

Behaviour:
- Interface: one clock, clk_in; reset is asynchronous and active-low, on rst_n_in.
- Reset: state IDLE; all outputs 0; byte counters 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration:
  - ls_req_in wins over if_req_in.
  - IF is granted only when ls_req_in=0 and if_flush_in=0.
  - Request fields are latched on accept; N = 1/2/4 bytes.
  - Accept edge is the end of cycle 0.
- READ:
  - Cycles 1..N: ram_a_out = addr+(c-1), ram_wr_out=0.
  - The byte addressed in cycle c is sampled from ram_din_in at the end of cycle c+1 into byte lane c-1.
  - After the last capture (end of cycle N+1), go to DONE.
- WRITE:
  - Cycles 1..N: ram_wr_out=1, ram_a_out=addr+(c-1), ram_dout_out = wdata byte c-1.
  - After cycle N, go to DONE.
- DONE: exactly one cycle.
  - Granted requester's done_out=1 with valid data.
  - No new accept in this cycle; next state IDLE.
  - Requester must drop or replace req at this edge.
- Latency (request seen to done): read N+2 cycles (word: 6); write N+1 cycles (word: 5).
- Load result: zero- or sign-extended from bit 8N-1 per latched sext.
- if_inst_out / ls_rdata_out hold their value until the next done for that port.
- Outside WRITE: ram_wr_out=0, ram_dout_out=0. ram_a_out=0 in IDLE/DONE.
- Address increment wraps modulo 2^32; no alignment check.
- if_flush_in during a granted IF READ: abort immediately (next state IDLE, no if_done_out, partial data discarded).
  - Flush has no effect on LS transactions.
  - Flush in the same cycle as the IF DONE suppresses if_done_out.
- rdy_in=0: all registers hold and ram_wr_out is forced 0.
  - On resume, an in-progress READ restarts from byte 0 (captured bytes discarded).
  - An in-progress WRITE re-drives the frozen byte, then continues.
  - A DONE frozen by rdy_in=0 keeps done_out low while paused and pulses on resume.
- rst_n_in low mid-transaction: immediate return to reset values; no done.

Decomposition:
- Shared package:
  - length encodings LEN_B/LEN_H/LEN_W
  - state enum
  - addrRange/dataRange constants
  - I/O base 0x30000
- One natural sub-module: mem_ctrl_rdata_fmt, combinational byte-lane assembly plus sign/zero extension.

Test Plan:
- Word fetch, addr 0x100, bytes 13 05 00 00 returned one cycle after each address -> ram_a 0x100..0x103 in cycles 1-4; if_done_out in cycle 6; if_inst_out=0x00000513.
- Simultaneous if_req and ls_req (LB 0x200, sext, byte 0x80) -> LS served first, ls_rdata_out=0xFFFFFF80 at cycle 3; IF accepted in the cycle after DONE.
- SW 0x11223344 to 0x1000 -> cycles 1-4: ram_wr=1, addr 0x1000..0x1003, dout 44 33 22 11; ls_done_out in cycle 5.
- if_flush_in asserted in cycle 2 of a word fetch -> no if_done_out, IDLE next cycle, a pending LS request accepted the following cycle.
- rdy_in low for 3 cycles during word READ byte 2 -> read restarts at addr+0, correct word returned, done delayed accordingly; rdy_in low during SH -> no ram_wr while low, both bytes written exactly once effectively.
- rst_n_in low mid-WRITE -> outputs 0 asynchronously; first request after release behaves as from reset.
